// File: rtl/farm_sensor_frontend.sv
// Farm-road vehicle sensor front end.
// Synchronizes the raw loop detector, qualifies presence, and raises a
// latched service request (farmSensor) toward the traffic-light controller.
// Optional feature macro: FARM_DEBOUNCE_EN
//   defined   -> presence must persist DEBOUNCE_CYCLES cycles in QUALIFY
//   undefined -> counter removed; QUALIFY moves to PENDING after one cycle
module farm_sensor_frontend #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       rawSensor,
  input  logic [1:0] farmSignal,
  output logic       farmSensor,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    QUALIFY = 3'd1,
    PENDING = 3'd2,
    SERVING = 3'd3,
    RELEASE = 3'd4
  } state_t;

  // Reject configurations where the counter cannot reach its terminal value.
  if (DEBOUNCE_CYCLES == 0 || 64'(DEBOUNCE_CYCLES) > (64'd1 << CNT_W)) begin : g_bad_cfg
    $error("farm_sensor_frontend: DEBOUNCE_CYCLES must be in 1..2**CNT_W");
  end

  state_t cur_state;
  logic   sensMeta;
  logic   sensSync;
  logic   green;

`ifdef FARM_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [CNT_W-1:0] cnt;
`endif

  assign state = cur_state;
  // Encoding 00 is green; 01 yellow, 10 red and 11 are all "not green".
  assign green = (farmSignal == 2'b00);

  // Two-flop synchronizer for the asynchronous loop detector.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would collapse the two stages into one.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sensMeta <= 1'b0;
      sensSync <= 1'b0;
    end else begin
      sensMeta <= rawSensor;
      sensSync <= sensMeta;
    end
  end

  // Request FSM with registered farmSensor (one cycle behind state entry).
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cur_state  <= IDLE;
      farmSensor <= 1'b0;
`ifdef FARM_DEBOUNCE_EN
      cnt        <= '0;
`endif
    end else begin
      // NOTE: default the request low up front so every branch, including
      // illegal codes, assigns it without a per-branch else.
      farmSensor <= 1'b0;
      case (cur_state)
        IDLE: begin
`ifdef FARM_DEBOUNCE_EN
          cnt <= '0;
`endif
          if (sensSync) cur_state <= QUALIFY;
        end

        QUALIFY: begin
`ifdef FARM_DEBOUNCE_EN
          // Any dropout discards accumulated presence; counter stops at
          // its terminal value, so it never wraps.
          if (!sensSync) begin
            cur_state <= IDLE;
            cnt       <= '0;
          end else if (cnt == CNT_LAST) begin
            cur_state <= PENDING;
            cnt       <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
`else
          // Presence was already seen in IDLE; one cycle here qualifies.
          cur_state <= PENDING;
`endif
        end

        PENDING: begin
          // Latched: a vehicle that drives off is still served.
          farmSensor <= 1'b1;
          if (green) cur_state <= SERVING;
        end

        SERVING: begin
          // Track presence so the controller may cut green short.
          farmSensor <= sensSync;
          if (!green) cur_state <= RELEASE;
        end

        RELEASE: cur_state <= IDLE;

        default: cur_state <= IDLE;
      endcase
    end
  end

endmodule
